key_search_scheduler: RTL and testbench
=======================================

Name: key_search_scheduler

Overview:
Dynamic key-space scheduler for a bank of RC4 decryption cores. It splits the 24-bit secret-key space into fixed-size slices and issues them round-robin to cores that request work. It detects the first core reporting a valid decryption, latches that key, and broadcasts halt to every core. If the space is exhausted with no hit, it flags exhaustion. It sits above the per-core key counters and drives their start-key load and outer_finish inputs.

Parameters:
NUM_CORES, 4, number of decryption cores served (2..16)
KEY_WIDTH, 24, secret key width in bits
KEY_LIMIT, 24'd4194304, first key outside the search space; keys searched are 0..KEY_LIMIT-1
SLICE_SIZE, 4096, keys per granted slice (power of two, less than or equal to KEY_LIMIT)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a new search from key 0
core_req  input  NUM_CORES  per-core level; slice finished with no hit / core idle, wants a slice
core_hit  input  NUM_CORES  per-core one-cycle pulse; valid message decrypted with current key
core_key  input  NUM_CORES*KEY_WIDTH  per-core current key, core i at bits [i*KEY_WIDTH +: KEY_WIDTH]
core_grant  output  NUM_CORES  one-hot one-cycle pulse; slice bus valid for that core
slice_base  output  KEY_WIDTH  first key of granted slice
slice_last  output  KEY_WIDTH  last key of granted slice, inclusive
halt_all  output  1  level; drives every core's outer_finish
busy  output  1  high while searching
found  output  1  level; hit latched
found_key  output  KEY_WIDTH  latched winning key
found_core  output  $clog2(NUM_CORES)  index of winning core
exhausted  output  1  level; space searched, no hit
perf_cycles  output  32  search-duration counter (see Optional Feature)
perf_slices  output  16  slices-issued counter (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state IDLE; next_key=0; active mask=0; RR pointer=0. Every output is 0.
- next_key is KEY_WIDTH+1 bits wide, so there is no wrap-around. It saturates at KEY_LIMIT.
- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED + start:
  - Go to SEARCH.
  - Clear next_key, active mask, found, found_key, found_core, exhausted and halt_all.
  - Set busy.
- SEARCH, grant:
  - A grant is issued in a cycle when there is no core_hit, some core_req is high and next_key < KEY_LIMIT.
  - Winner is the first requesting index at or after the RR pointer, wrapping modulo NUM_CORES.
  - Registered outputs next cycle: core_grant one-hot; slice_base=next_key; slice_last=min(next_key+SLICE_SIZE, KEY_LIMIT)-1.
  - next_key += SLICE_SIZE, saturating. RR pointer = winner+1 mod NUM_CORES. Winner's active bit set.
  - At most one grant per cycle. A core holds core_req until it sees core_grant and drops it the next cycle.
  - A core with core_grant high in the current cycle is masked from arbitration, so no back-to-back double grant.
- SEARCH, core_req asserted by a core whose active bit is set: clear that active bit (slice completed).
- SEARCH, hit:
  - Any core_hit moves the state to FOUND the next cycle. The lowest index wins on simultaneous hits.
  - Latch found_key=core_key[winner] and found_core=winner. Set found and halt_all. Clear busy.
  - A hit has priority over a grant in the same cycle; no grant is issued.
- SEARCH, exhaustion: when next_key == KEY_LIMIT, active mask == 0 and no core_hit, go to EXHAUSTED. Set exhausted and halt_all. Clear busy.
- start while in SEARCH is ignored.
- core_hit outside SEARCH is ignored; found_key is never overwritten until the next start.
- Once halt_all is set, no core_grant is issued.
- Reset mid-search: immediate return to reset values; cores are expected to be reset together with the scheduler.

Optional Feature:
SCHED_PERF_CNT_EN.
- Defined:
  - perf_cycles clears on start and increments every SEARCH cycle, saturating at 2^32-1.
  - perf_slices clears on start and increments per grant, saturating at 2^16-1.
  - Both hold their value in FOUND/EXHAUSTED.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Config: NUM_CORES=4, SLICE_SIZE=16, KEY_LIMIT=64. start, then all core_req high -> grants in order to cores 0,1,2,3 on consecutive cycles with slice_base 0,16,32,48 and slice_last 15,31,47,63. No fifth grant.
- Same config: cores complete slices in order with no hits -> exhausted=1 and halt_all=1 one cycle after the last active bit clears; found=0; busy=0.
- Mid-search: core_hit[2] with core_key[2]=24'h00002A -> found=1, found_key=24'h00002A, found_core=2, halt_all=1. No grants afterward even with core_req high.
- Simultaneous core_hit[1] and core_hit[3], keys 5 and 50 -> found_core=1, found_key=5. A pending core_req on the same cycle receives no grant.
- After grant to core 3, requests from cores 0 and 3 pending -> next grant goes to core 0 (RR wrap), then core 3.
- reset_n low for 1 cycle during SEARCH -> all outputs 0 immediately. A following start restarts at slice_base=0. With SCHED_PERF_CNT_EN, perf_slices counts 4 after the first scenario.

Source files
------------

// File: rtl/key_search_scheduler.sv
`timescale 1ns/1ps
// Purpose: splits the key space into fixed slices, grants them round-robin to requesting RC4 cores, latches the first hit and halts all cores.
// Latency: core_grant/slice bus and all status outputs are registered, one cycle after the qualifying core_req/core_hit/start.
// Backpressure: level core_req is the only flow control; at most one grant per cycle, and a core is masked while its grant is visible.
// Ports: clk/reset_n (async active-low); start pulse; per-core core_req/core_hit/core_key in;
//        core_grant + slice_base/slice_last out; halt_all, busy, found, found_key, found_core, exhausted status; perf_cycles/perf_slices.
// Option: define SCHED_PERF_CNT_EN to build the perf counters; otherwise perf_cycles/perf_slices are tied to 0.
module key_search_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int KEY_WIDTH  = 24,
  parameter int KEY_LIMIT  = 4194304,
  parameter int SLICE_SIZE = 4096
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_hit,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic [NUM_CORES-1:0]           core_grant,
  output logic [KEY_WIDTH-1:0]           slice_base,
  output logic [KEY_WIDTH-1:0]           slice_last,
  output logic                           halt_all,
  output logic                           busy,
  output logic                           found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [$clog2(NUM_CORES)-1:0]   found_core,
  output logic                           exhausted,
  output logic [31:0]                    perf_cycles,
  output logic [15:0]                    perf_slices
);

  localparam int IDX_W = $clog2(NUM_CORES);
  // One extra bit so next_key can sit exactly at KEY_LIMIT without wrapping.
  localparam int NK_W = KEY_WIDTH + 1;
  localparam logic [NK_W-1:0]  LIMIT    = NK_W'(KEY_LIMIT);
  localparam logic [NK_W-1:0]  SLICE    = NK_W'(SLICE_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, FOUND, EXHAUSTED} state_t;

  state_t                state, state_nxt;
  logic [NK_W-1:0]       next_key, next_key_nxt;
  logic [NUM_CORES-1:0]  active, active_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [NUM_CORES-1:0]  grant_nxt;
  logic [KEY_WIDTH-1:0]  base_nxt, last_nxt, found_key_nxt;
  logic [IDX_W-1:0]      found_core_nxt;
  logic                  halt_nxt, busy_nxt, found_nxt, exhausted_nxt;

  logic [NUM_CORES-1:0]  req_elig;
  logic                  grant_any, hit_any;
  logic [IDX_W-1:0]      grant_idx, hit_idx;
  logic [NK_W-1:0]       key_sum, key_adv;

  // A core whose grant is on the bus right now still holds core_req; ignore it
  // both for arbitration and for slice-completion this cycle.
  assign req_elig = core_req & ~core_grant;

  // Saturating advance; slice_last is derived from the clipped value.
  assign key_sum = next_key + SLICE;
  assign key_adv = (key_sum > LIMIT) ? LIMIT : key_sum;

  // Round-robin: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    int c;
    c         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      c = (int'(rr_ptr) + k) % NUM_CORES;
      if (!grant_any && req_elig[c]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

  // Lowest-index hit wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    next_key_nxt   = next_key;
    active_nxt     = active;
    rr_ptr_nxt     = rr_ptr;
    grant_nxt      = '0;
    base_nxt       = slice_base;
    last_nxt       = slice_last;
    halt_nxt       = halt_all;
    busy_nxt       = busy;
    found_nxt      = found;
    found_key_nxt  = found_key;
    found_core_nxt = found_core;
    exhausted_nxt  = exhausted;
    case (state)
      SEARCH: begin
        if (hit_any) begin
          state_nxt      = FOUND;
          found_nxt      = 1'b1;
          found_key_nxt  = core_key[hit_idx*KEY_WIDTH +: KEY_WIDTH];
          found_core_nxt = hit_idx;
          halt_nxt       = 1'b1;
          busy_nxt       = 1'b0;
        end else if (next_key == LIMIT && active == '0) begin
          state_nxt     = EXHAUSTED;
          exhausted_nxt = 1'b1;
          halt_nxt      = 1'b1;
          busy_nxt      = 1'b0;
        end else begin
          active_nxt = active & ~req_elig;
          if (grant_any && next_key < LIMIT) begin
            grant_nxt[grant_idx]  = 1'b1;
            active_nxt[grant_idx] = 1'b1;
            base_nxt              = next_key[KEY_WIDTH-1:0];
            last_nxt              = KEY_WIDTH'(key_adv - 1'b1);
            next_key_nxt          = key_adv;
            rr_ptr_nxt            = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_nxt      = SEARCH;
          next_key_nxt   = '0;
          active_nxt     = '0;
          found_nxt      = 1'b0;
          found_key_nxt  = '0;
          found_core_nxt = '0;
          exhausted_nxt  = 1'b0;
          halt_nxt       = 1'b0;
          busy_nxt       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      next_key   <= '0;
      active     <= '0;
      rr_ptr     <= '0;
      core_grant <= '0;
      slice_base <= '0;
      slice_last <= '0;
      halt_all   <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      found_key  <= '0;
      found_core <= '0;
      exhausted  <= 1'b0;
    end else begin
      state      <= state_nxt;
      next_key   <= next_key_nxt;
      active     <= active_nxt;
      rr_ptr     <= rr_ptr_nxt;
      core_grant <= grant_nxt;
      slice_base <= base_nxt;
      slice_last <= last_nxt;
      halt_all   <= halt_nxt;
      busy       <= busy_nxt;
      found      <= found_nxt;
      found_key  <= found_key_nxt;
      found_core <= found_core_nxt;
      exhausted  <= exhausted_nxt;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_slices <= '0;
    end else if (state != SEARCH) begin
      if (start) begin
        perf_cycles <= '0;
        perf_slices <= '0;
      end
    end else begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if ((|grant_nxt) && perf_slices != '1) perf_slices <= perf_slices + 16'd1;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_slices = '0;
`endif

endmodule

// File: tb/tb_key_search_scheduler.sv
`timescale 1ns/1ps
// Purpose: randomized and directed check of key_search_scheduler against a slice-level reference model.
// Latency: model predicts the registered outputs one cycle after each set of inputs.
// Backpressure: bench cores hold core_req through their visible grant, then work a random number of cycles.
module tb_key_search_scheduler;

  localparam int NC  = 4;
  localparam int KW  = 24;
  localparam int LIM = 64;
  localparam int SS  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [NC-1:0]     core_req, core_hit, core_grant;
  logic [NC*KW-1:0]  core_key;
  logic [KW-1:0]     slice_base, slice_last, found_key;
  logic              halt_all, busy, found, exhausted;
  logic [1:0]        found_core;
  logic [31:0]       perf_cycles;
  logic [15:0]       perf_slices;

  key_search_scheduler #(
    .NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_LIMIT(LIM), .SLICE_SIZE(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .core_req(core_req), .core_hit(core_hit), .core_key(core_key),
    .core_grant(core_grant), .slice_base(slice_base), .slice_last(slice_last),
    .halt_all(halt_all), .busy(busy), .found(found), .found_key(found_key),
    .found_core(found_core), .exhausted(exhausted),
    .perf_cycles(perf_cycles), .perf_slices(perf_slices)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model: slices handed out in key order ----------------
  bit          m_search;
  int          m_next, m_ptr, m_base, m_last, m_fkey, m_fcore, m_slices, m_cycles;
  bit          m_owns[NC];
  bit [NC-1:0] m_grant;
  bit          m_halt, m_busy, m_found, m_exh;
  int          key_of[NC];

  task automatic model_reset();
    m_search = 0; m_next = 0; m_ptr = 0; m_base = 0; m_last = 0;
    m_fkey = 0; m_fcore = 0; m_slices = 0; m_cycles = 0;
    m_grant = '0; m_halt = 0; m_busy = 0; m_found = 0; m_exh = 0;
    for (int i = 0; i < NC; i++) m_owns[i] = 0;
  endtask

  task automatic model_step();
    bit [NC-1:0] on_bus;
    bit [NC-1:0] elig;
    bit          any_owned;
    bit          got;
    int          w;
    on_bus  = m_grant;
    m_grant = '0;
    w       = 0;
    got     = 0;
    if (!m_search) begin
      if (start) begin
        m_search = 1; m_next = 0; m_found = 0; m_fkey = 0; m_fcore = 0;
        m_exh = 0; m_halt = 0; m_busy = 1; m_slices = 0; m_cycles = 0;
        for (int i = 0; i < NC; i++) m_owns[i] = 0;
      end
    end else begin
      m_cycles++;
      if (core_hit != '0) begin
        for (int i = NC - 1; i >= 0; i--) if (core_hit[i]) w = i;
        m_found = 1; m_fkey = key_of[w]; m_fcore = w;
        m_halt = 1; m_busy = 0; m_search = 0;
      end else begin
        elig = core_req & ~on_bus;
        any_owned = 0;
        for (int i = 0; i < NC; i++) any_owned |= m_owns[i];
        for (int i = 0; i < NC; i++) if (elig[i]) m_owns[i] = 0;
        if (m_next == LIM && !any_owned) begin
          m_exh = 1; m_halt = 1; m_busy = 0; m_search = 0;
        end else if (m_next < LIM && elig != '0) begin
          for (int k = 0; k < NC; k++) begin
            if (!got && elig[(m_ptr + k) % NC]) begin
              got = 1;
              w = (m_ptr + k) % NC;
            end
          end
          m_grant[w] = 1;
          m_owns[w]  = 1;
          m_base     = m_next;
          m_next     = (m_next + SS > LIM) ? LIM : m_next + SS;
          m_last     = m_next - 1;
          m_ptr      = (w + 1) % NC;
          m_slices++;
        end
      end
    end
  endtask

  // ---------------- one clock: predict, advance, compare ----------------
  int gq[$];
  int bq[$];
  int lq[$];
  int tq[$];

  task automatic tick();
    int g;
    for (int i = 0; i < NC; i++) core_key[i*KW +: KW] = KW'(key_of[i]);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("grant", core_grant, m_grant);
    if (m_grant != '0) begin
      chk("slice_base", slice_base, m_base);
      chk("slice_last", slice_last, m_last);
    end
    chk("status{halt,busy,found,exh}", {halt_all, busy, found, exhausted}, {m_halt, m_busy, m_found, m_exh});
    chk("found_key", found_key, m_fkey);
    chk("found_core", found_core, m_fcore);
`ifdef SCHED_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, m_cycles);
    chk("perf_slices", perf_slices, m_slices);
`else
    chk("perf_tied", {perf_cycles, perf_slices}, 0);
`endif
    if (core_grant != '0) begin
      g = 99;
      for (int i = 0; i < NC; i++) if (core_grant[i]) g = i;
      gq.push_back(g); bq.push_back(int'(slice_base)); lq.push_back(int'(slice_last)); tq.push_back(cyc);
    end
  endtask

  // ---------------- bench cores ----------------
  localparam int C_REQ = 0, C_GOT = 1, C_WORK = 2;
  int cst[NC];
  int wcnt[NC];
  bit has_slice[NC];
  int lo[NC], hi[NC];
  int hit_pm, wmin, wmax;

  task automatic cores_update();
    core_hit = '0;
    for (int i = 0; i < NC; i++) begin
      key_of[i] = int'($urandom_range(0, 255));
      case (cst[i])
        C_REQ: begin
          core_req[i] = 1'b1;
          if (m_grant[i]) begin
            cst[i] = C_GOT; has_slice[i] = 1; lo[i] = m_base; hi[i] = m_last;
          end
        end
        C_GOT: begin
          core_req[i] = 1'b0; cst[i] = C_WORK;
          wcnt[i] = int'($urandom_range(wmin, wmax));
        end
        default: begin
          core_req[i] = 1'b0;
          if (wcnt[i] <= 0) begin
            cst[i] = C_REQ; core_req[i] = 1'b1; has_slice[i] = 0;
          end else begin
            wcnt[i]--;
            if (has_slice[i] && m_search && int'($urandom_range(0, 999)) < hit_pm) begin
              core_hit[i] = 1'b1;
              key_of[i] = int'($urandom_range(lo[i], hi[i]));
            end
          end
        end
      endcase
    end
  endtask

  task automatic begin_search(input int pm, input int w0, input int w1, input bit stagger);
    hit_pm = pm; wmin = w0; wmax = w1;
    for (int i = 0; i < NC; i++) begin
      has_slice[i] = 0;
      if (stagger) begin
        cst[i] = C_WORK; wcnt[i] = int'($urandom_range(0, 3)); core_req[i] = 1'b0;
      end else begin
        cst[i] = C_REQ; core_req[i] = 1'b1;
      end
    end
    core_hit = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_end(input int max_cycles);
    int c;
    c = 0;
    while (m_search && c < max_cycles) begin
      cores_update();
      start = ($urandom_range(0, 49) == 0);
      tick();
      start = 1'b0;
      c++;
    end
    chk("search_ends", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {core_grant, slice_base, slice_last, halt_all, busy, found, exhausted}, 0);
    chk({tag, "_b"}, {found_key, found_core, perf_slices}, 0);
    chk({tag, "_c"}, perf_cycles, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; core_req = '0; core_hit = '0; core_key = '0;
    for (int i = 0; i < NC; i++) begin key_of[i] = 0; cst[i] = C_REQ; wcnt[i] = 0; end
    model_reset();
    #12;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // In-order grants 0..3 with bases 0,16,32,48, no fifth grant, then exhaustion.
    gq.delete(); bq.delete(); lq.delete(); tq.delete();
    begin_search(0, 8, 8, 1'b0);
    run_to_end(200);
    chk("t1_num_grants", gq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_core",  (k < gq.size()) ? gq[k] : 99, k);
      chk("t1_base",  (k < bq.size()) ? bq[k] : 999, 16 * k);
      chk("t1_last",  (k < lq.size()) ? lq[k] : 999, 16 * k + 15);
      chk("t1_consec", (k < tq.size()) ? tq[k] - tq[0] : 99, k);
    end
    chk("t1_done", {exhausted, halt_all, found, busy}, 4'b1100);
`ifdef SCHED_PERF_CNT_EN
    chk("t1_perf_slices", perf_slices, 4);
`endif

    // Mid-search hit on core 2, then no grants despite requests.
    begin_search(0, 20, 20, 1'b0);
    for (int k = 0; k < 4; k++) begin cores_update(); tick(); end
    cores_update();
    core_hit = '0; core_hit[2] = 1'b1; key_of[2] = 42;
    tick();
    core_hit = '0;
    chk("t3_found", {found, halt_all, busy}, 3'b110);
    chk("t3_found_key", found_key, 24'h00002A);
    chk("t3_found_core", found_core, 2);
    core_req = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_no_grant", core_grant, 0);
    end

    // Simultaneous hits on 1 and 3 with a pending request.
    core_req = '0; start = 1'b1; tick(); start = 1'b0;
    core_req = 4'b0001; core_hit = 4'b1010; key_of[1] = 5; key_of[3] = 50;
    tick();
    core_hit = '0; core_req = '0;
    chk("t4_no_grant", core_grant, 0);
    chk("t4_found_core", found_core, 1);
    chk("t4_found_key", found_key, 5);

    // Round-robin wrap after a grant to core 3.
    start = 1'b1; tick(); start = 1'b0;
    core_req = 4'b1000; tick();
    chk("t5_grant3", core_grant, 4'b1000);
    core_req = 4'b0000; tick();
    core_req = 4'b1001; tick();
    chk("t5_wrap0", core_grant, 4'b0001);
    tick();
    chk("t5_then3", core_grant, 4'b1000);

    // Asynchronous reset mid-search, then a clean restart from key 0.
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    core_req = '0;
    begin_search(0, 3, 3, 1'b0);
    cores_update(); tick();
    chk("t6_first_grant", core_grant, 4'b0001);
    chk("t6_first_base", slice_base, 0);
    run_to_end(200);

    // Randomized searches, some with hits, plus ignored hits afterwards.
    for (int r = 0; r < 40; r++) begin
      begin_search((r % 3 == 0) ? 0 : int'($urandom_range(5, 60)), 1, 8, 1'($urandom_range(0, 1)));
      run_to_end(500);
      for (int k = 0; k < 3; k++) begin
        core_hit = NC'($urandom);
        for (int i = 0; i < NC; i++) key_of[i] = int'($urandom_range(0, 255));
        tick();
      end
      core_hit = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
